// File: rtl/mul_pkg.sv
// mul_pkg -- shared types and constants for the sequential multiplier.
//   mul_state_t : control FSM states (IDLE, RUN, DONE)
//   cnt_width() : iteration-counter width for a given operand width
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int unsigned MUL_WIDTH_DEFAULT = 32;

  // A 1-bit operand still needs a 1-bit counter, so the width never drops to 0.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int unsigned MUL_CNT_W = cnt_width(MUL_WIDTH_DEFAULT);

endpackage

// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if -- request/response bundle for mul_sequencer.
//   master : the requester (control FSM or bench) drives Start/Cancel/operands
//   slave  : the multiplier side drives Busy/Done/Result/N/Z
// Member names match the mul_sequencer ports so the bundle wires straight in.
interface mul_sequencer_if
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH_DEFAULT
);
  logic             Start;
  logic             Cancel;
  logic             AccEn;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] Acc;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic             N;
  logic             Z;

  modport master (
    output Start, Cancel, AccEn, SrcA, SrcB, Acc,
    input  Busy, Done, Result, N, Z
  );

  modport slave (
    input  Start, Cancel, AccEn, SrcA, SrcB, Acc,
    output Busy, Done, Result, N, Z
  );
endinterface

// File: rtl/mul_datapath.sv
// mul_datapath -- shift-and-add datapath for mul_sequencer.
//   clk, reset   : clock, synchronous active-low reset
//   load         : capture operands, seed partial product with Acc or 0
//   step         : one shift-and-add iteration
//   acc_en       : select Acc (1) or 0 (0) as the partial-product seed
//   src_a/src_b  : multiplicand / multiplier
//   acc          : accumulate addend
//   pp_next      : partial product after the current iteration's add
//   mplier_last  : multiplier becomes 0 after the current shift
module mul_datapath
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             acc_en,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] pp_next,
  output logic             mplier_last
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] pp;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand  <= '0;
      mplier <= '0;
      pp     <= '0;
    end else if (load) begin
      mcand  <= src_a;
      mplier <= src_b;
      pp     <= acc_en ? acc : '0;
    end else if (step) begin
      pp     <= pp_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // Sum wraps modulo 2^WIDTH; carries out of the top bit are dropped.
  always_comb begin
    pp_next     = pp + (mplier[0] ? mcand : '0);
    mplier_last = ((mplier >> 1) == '0);
  end

endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer -- sequential unsigned multiply / multiply-accumulate.
//   clk, reset         : clock, synchronous active-low reset
//   Start, Cancel      : request (sampled in IDLE) / abort a running operation
//   AccEn              : 1 = Result = SrcA*SrcB + Acc, 0 = SrcA*SrcB
//   SrcA, SrcB, Acc    : operands
//   Busy               : high in RUN and DONE
//   Done               : one-cycle pulse when Result is valid
//   Result, N, Z       : registered result and flags, held until next completion
// RUN length is max(1, msb_index(SrcB)+1) cycles thanks to the early exit.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Cancel,
  input  logic             AccEn,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [WIDTH-1:0] Acc,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             N,
  output logic             Z
);

  localparam int unsigned     CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  mul_state_t       state;
  mul_state_t       state_next;
  logic [CW-1:0]    cnt;
  logic             load;
  logic             step;
  logic             finish;
  logic [WIDTH-1:0] pp_next;
  logic             mplier_last;

  mul_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .acc_en     (AccEn),
    .src_a      (SrcA),
    .src_b      (SrcB),
    .acc        (Acc),
    .pp_next    (pp_next),
    .mplier_last(mplier_last)
  );

  assign finish = mplier_last || (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Cancel outranks completion: a cancelled last iteration never reaches DONE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (Start && !Cancel) state_next = RUN;
      RUN: begin
        if (Cancel)      state_next = IDLE;
        else if (finish) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == RUN) || (state == DONE);
    Done = (state == DONE);
    load = (state == IDLE) && Start && !Cancel;
    step = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Result is taken straight from the adder so it is valid in the DONE cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      Result <= '0;
      N      <= 1'b0;
      Z      <= 1'b0;
    end else if ((state == RUN) && !Cancel && finish) begin
      Result <= pp_next;
      N      <= pp_next[WIDTH-1];
      Z      <= (pp_next == '0);
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_sequencer_if #(.WIDTH(W)) bus ();

  mul_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (bus.Start),
    .Cancel(bus.Cancel),
    .AccEn (bus.AccEn),
    .SrcA  (bus.SrcA),
    .SrcB  (bus.SrcB),
    .Acc   (bus.Acc),
    .Busy  (bus.Busy),
    .Done  (bus.Done),
    .Result(bus.Result),
    .N     (bus.N),
    .Z     (bus.Z)
  );

  typedef struct {
    logic [W-1:0]    res;
    int unsigned     k;
    longint unsigned t0;
  } exp_t;

  exp_t            sb[$];
  int              checks   = 0;
  int              failures = 0;
  longint unsigned cyc      = 0;
  logic            mon_en   = 1'b0;
  logic [W-1:0]    hold_res = '0;
  logic            hold_n   = 1'b0;
  logic            hold_z   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain modular arithmetic and the multiplier's bit length.
  function automatic logic [W-1:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] acc, input bit accen);
    logic [2*W-1:0] full;
    full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return full[W-1:0] + (accen ? acc : {W{1'b0}});
  endfunction

  function automatic int unsigned model_len(input logic [W-1:0] b);
    int unsigned k = 1;
    for (int i = 0; i < W; i++) if (b[i]) k = i + 1;
    return k;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every Done, else verifies outputs hold.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (bus.Done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0 result=%0h", bus.Result);
        end else begin
          e = sb.pop_front();
          check("result", 64'(bus.Result), 64'(e.res));
          check("n_flag", 64'(bus.N), 64'(e.res[W-1]));
          check("z_flag", 64'(bus.Z), 64'(e.res == '0));
          check("done_latency", cyc - e.t0, 64'(e.k));
          hold_res = e.res;
          hold_n   = e.res[W-1];
          hold_z   = (e.res == '0);
        end
      end else begin
        check("hold_outputs", 64'({bus.Result, bus.N, bus.Z}), 64'({hold_res, hold_n, hold_z}));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int unsigned g = 0;
    while (bus.Busy !== 1'b0) begin
      tick();
      g++;
      if (g > 100) begin
        checks++;
        failures++;
        $display("FAIL idle_timeout actual=busy required=idle");
        break;
      end
    end
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] acc,
                          input bit accen, input bit track, output longint unsigned t0);
    exp_t e;
    wait_idle();
    bus.SrcA  = a;
    bus.SrcB  = b;
    bus.Acc   = acc;
    bus.AccEn = accen;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    t0 = cyc;
    if (track) begin
      e.res = model_res(a, b, acc, accen);
      e.k   = model_len(b);
      e.t0  = t0;
      sb.push_back(e);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    longint unsigned t0;
    logic [W-1:0] a, b, acc;
    int unsigned j;

    bus.Start  = 1'b0;
    bus.Cancel = 1'b0;
    bus.AccEn  = 1'b0;
    bus.SrcA   = '0;
    bus.SrcB   = '0;
    bus.Acc    = '0;
    reset      = 1'b0;
    repeat (3) tick();
    check("reset_busy", 64'(bus.Busy), 64'd0);
    check("reset_done", 64'(bus.Done), 64'd0);
    check("reset_result", 64'(bus.Result), 64'd0);
    check("reset_n", 64'(bus.N), 64'd0);
    check("reset_z", 64'(bus.Z), 64'd0);
    reset  = 1'b1;
    mon_en = 1'b1;

    // 7*6 = 0x2A, 3 RUN cycles
    start_op(32'd7, 32'd6, 32'd0, 1'b0, 1'b1, t0);
    check("busy_after_start", 64'(bus.Busy), 64'd1);

    // All-ones MLA: 32 RUN cycles, wraps to 3
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1, t0);

    // Zero multiplier: 1 RUN cycle, Z=1
    start_op(32'h1234, 32'd0, 32'd0, 1'b0, 1'b1, t0);

    // N flag; Start during RUN is ignored
    start_op(32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b1, t0);
    bus.SrcA  = 32'd5;
    bus.SrcB  = 32'd5;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;

    // Start with Cancel in IDLE is ignored
    wait_idle();
    repeat (2) tick();
    bus.Cancel = 1'b1;
    bus.Start  = 1'b1;
    tick();
    bus.Start  = 1'b0;
    bus.Cancel = 1'b0;
    check("idle_cancel_blocks_start", 64'(bus.Busy), 64'd0);

    // Cancel in DONE has no effect
    start_op(32'd3, 32'd1, 32'd0, 1'b0, 1'b1, t0);
    tick();
    bus.Cancel = 1'b1;
    tick();
    bus.Cancel = 1'b0;

    // 7*6, then cancel 5*0xFF in its 3rd RUN cycle
    start_op(32'd7, 32'd6, 32'd0, 1'b0, 1'b1, t0);
    start_op(32'd5, 32'hFF, 32'd0, 1'b0, 1'b0, t0);
    tick();
    tick();
    bus.Cancel = 1'b1;
    tick();
    bus.Cancel = 1'b0;
    check("cancel_busy", 64'(bus.Busy), 64'd0);
    check("cancel_result", 64'(bus.Result), 64'h2A);
    repeat (12) tick();

    // Random operations, some with ignored Start pulses mid-RUN
    for (int n = 0; n < 30; n++) begin
      a   = $urandom;
      b   = $urandom >> $urandom_range(0, 31);
      acc = $urandom;
      start_op(a, b, acc, 1'($urandom_range(0, 1)), 1'b1, t0);
      if ($urandom_range(0, 2) == 0) begin
        j = $urandom_range(0, model_len(b) - 1);
        repeat (j) tick();
        bus.SrcA  = $urandom;
        bus.SrcB  = $urandom;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
      end
      if ($urandom_range(0, 1) == 0) begin
        wait_idle();
        repeat ($urandom_range(0, 3)) tick();
      end
    end

    // Reset in the 10th RUN cycle of a 32-cycle operation
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, t0);
    repeat (9) tick();
    reset = 1'b0;
    tick();
    hold_res = '0;
    hold_n   = 1'b0;
    hold_z   = 1'b0;
    check("midrun_reset_busy", 64'(bus.Busy), 64'd0);
    check("midrun_reset_done", 64'(bus.Done), 64'd0);
    check("midrun_reset_result", 64'(bus.Result), 64'd0);
    check("midrun_reset_n", 64'(bus.N), 64'd0);
    check("midrun_reset_z", 64'(bus.Z), 64'd0);
    reset = 1'b1;
    repeat (40) tick();

    wait_idle();
    repeat (5) tick();
    check("pending_results", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1: synchronous, active-low reset (0 = reset).
REQ-004 SHALL have port Start  input  1: request a multiply, sampled only in IDLE.
REQ-005 SHALL have port Cancel  input  1: abort the operation in progress.
REQ-006 SHALL have port AccEn  input  1: 1 = MLA (add Acc), 0 = MUL.
REQ-007 SHALL have port SrcA  input  WIDTH: multiplicand.
REQ-008 SHALL have port SrcB  input  WIDTH: multiplier.
REQ-009 SHALL have port Acc  input  WIDTH: accumulate addend.
REQ-010 SHALL have port Busy  output  1: high in RUN and DONE; stalls the main control FSM.
REQ-011 SHALL have port Done  output  1: one-cycle pulse when Result is valid.
REQ-012 SHALL have port Result  output  WIDTH: low WIDTH bits of SrcA*SrcB (+Acc).
REQ-013 SHALL have port N  output  1: Result[WIDTH-1].
REQ-014 SHALL have port Z  output  1: Result == 0.

Function
REQ-015 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-016 IDLE with Start=1 and Cancel=0 SHALL latch SrcA, SrcB, Acc and AccEn, load the partial product with AccEn ? Acc : 0, clear the iteration counter and move to RUN.
REQ-017 IDLE SHALL ignore Start while Cancel=1.
REQ-018 Each RUN cycle SHALL add the multiplicand to the partial product when the multiplier LSB=1, then shift the multiplicand left 1 and the multiplier right 1 (logical), then increment the counter.
REQ-019 RUN SHALL go to DONE when the shifted multiplier is 0 or the counter has reached WIDTH-1 (early exit); RUN length SHALL be max(1, msb_index(SrcB)+1) cycles.
REQ-020 On the transition to DONE, Result, N and Z SHALL be registered; these outputs SHALL hold their values until the next completed operation.
REQ-021 DONE SHALL last exactly one cycle with Done=1, then go to IDLE unconditionally.
REQ-022 With Start accepted at edge t, Done SHALL be high in the cycle after edge t+k, where k is the RUN length.
REQ-023 Arithmetic SHALL be unsigned and modulo 2^WIDTH; overflow SHALL be discarded silently.
REQ-024 Start SHALL be ignored in RUN and DONE, with no queuing.
REQ-025 Cancel=1 in RUN SHALL force IDLE at the next edge; Done SHALL not pulse and Result, N and Z SHALL stay unchanged.
REQ-026 Cancel in DONE SHALL have no effect.
REQ-027 Busy SHALL be combinational from state (RUN or DONE); Done SHALL be combinational from state (DONE).

Reset
REQ-028 reset=0 at a rising edge SHALL force IDLE from any state, including mid-RUN.
REQ-029 Reset SHALL clear Result, N, Z, the counter and all operand registers to 0, giving Busy=0 and Done=0.
REQ-030 Reset SHALL override Start and Cancel in the same cycle.

Structure
REQ-031 Package mul_pkg SHALL hold the state enum mul_state_t (IDLE, RUN, DONE) and the counter-width constant derived from WIDTH ($clog2(WIDTH)).
REQ-032 A single sub-module, mul_datapath, SHALL hold the multiplicand/multiplier shift registers, partial-product register and adder; mul_sequencer SHALL hold the FSM, counter and output registers.
REQ-033 The design SHALL contain no latches and no asynchronous logic.

Verification
REQ-034 SrcA=7, SrcB=6, AccEn=0, Start at edge t -> Busy high from t; 3 RUN cycles; Done pulses after edge t+3; Result=0x2A, N=0, Z=0.
REQ-035 SrcA=SrcB=0xFFFFFFFF, Acc=2, AccEn=1 -> 32 RUN cycles; Result=0x00000003, N=0, Z=0.
REQ-036 SrcA=0x1234, SrcB=0, AccEn=0 -> 1 RUN cycle; Done after edge t+1; Result=0, Z=1.
REQ-037 SrcA=0x80000000, SrcB=1 -> Result=0x80000000, N=1; a Start pulse during that RUN -> ignored, exactly one Done.
REQ-038 Complete 7*6, then start 5*0xFF and assert Cancel in the 3rd RUN cycle -> IDLE at the next edge; no Done; Result stays 0x2A.
REQ-039 reset=0 during the 10th RUN cycle of a 32-cycle operation -> next edge: IDLE, Busy=0, Done=0, Result=0, N=0, Z=0.
